// File: rtl/fifo_reader.sv
// Byte FIFO drain into a 2-entry buffer, valid/ready out; strobe-to-valid is 2 edges and one read per 3 cycles.
// Reads stop while the buffer plus the in-flight byte would overflow; FIFO_READER_CKSUM_EN adds port cksum.
module fifo_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] fifo_n,
  input  logic [7:0] fifo_dout,
  output logic       fifo_eno,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] cnt,
`ifdef FIFO_READER_CKSUM_EN
  output logic [7:0] cksum,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CAP  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_mem [0:1];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;
  logic [7:0] r_cnt;
  logic       w_xfer;
  logic       w_wr;

  assign w_xfer = m_valid & m_ready;
  assign w_wr   = (r_state == S_CAP);

  // Only IDLE can issue a read, so a read is never outstanding when count is checked.
  always_comb begin
    w_state_nxt = r_state;
    fifo_eno    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && (fifo_n != 5'd0) && (r_count < 2'd2)) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        fifo_eno    = 1'b1;
        w_state_nxt = S_CAP;
      end
      S_CAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= 2'd0;
      r_cnt    <= 8'd0;
      r_mem[0] <= 8'd0;
      r_mem[1] <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr) begin
        r_mem[r_tail] <= fifo_dout;
        r_tail        <= ~r_tail;
      end
      if (w_xfer) begin
        r_head <= ~r_head;
        r_cnt  <= r_cnt + 8'd1;
      end
      case ({w_wr, w_xfer})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_data  = r_mem[r_head];
  assign m_valid = (r_count != 2'd0);
  assign busy    = (r_state != S_IDLE) | m_valid;
  assign cnt     = r_cnt;

`ifdef FIFO_READER_CKSUM_EN
  logic [7:0] r_cksum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cksum <= 8'd0;
    end else if (w_xfer) begin
      r_cksum <= r_cksum + m_data;
    end
  end

  assign cksum = r_cksum;
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low (rst=0 at a rising clk edge resets).
REQ-003 SHALL have port en  input  1  drain enable; 0 blocks new FIFO reads.
REQ-004 SHALL have port fifo_n  input  5  current FIFO occupancy, 0..16.
REQ-005 SHALL have port fifo_dout  input  8  FIFO read data, valid the cycle after fifo_eno is sampled high.
REQ-006 SHALL have port fifo_eno  output  1  FIFO read strobe, one-cycle pulse per byte.
REQ-007 SHALL have port m_data  output  8  downstream byte.
REQ-008 SHALL have port m_valid  output  1  m_data holds a byte.
REQ-009 SHALL have port m_ready  input  1  downstream accepts; transfer = m_valid & m_ready at a rising edge.
REQ-010 SHALL have port cnt  output  8  bytes transferred downstream, mod 256.
REQ-011 SHALL have port busy  output  1  high when the FSM is not in IDLE or the buffer is non-empty.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, CAP.
REQ-013 IDLE->REQ SHALL occur when en=1, fifo_n!=0 and buffer occupancy (including the in-flight byte) <2; otherwise the FSM SHALL stay in IDLE.
REQ-014 In REQ, fifo_eno SHALL be 1 for exactly that cycle, then REQ->CAP unconditionally.
REQ-015 In CAP, fifo_dout SHALL be written into the buffer, then CAP->IDLE; fifo_eno SHALL be 0 in IDLE and CAP.
REQ-016 fifo_eno pulses SHALL be at least 3 cycles apart, so fifo_n updates before it is re-sampled; the FIFO SHALL never be read while empty.
REQ-017 Buffer SHALL be a 2-entry FIFO (head/tail pointers, 2-bit count); m_data SHALL be the head entry, m_valid=(count!=0).
REQ-018 A transfer SHALL pop the head; a CAP write and a transfer in the same cycle SHALL leave count unchanged, keeping order.
REQ-019 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-020 Latency SHALL be: fifo_eno high at edge k -> byte captured at edge k+1 -> m_valid=1 after edge k+1.
REQ-021 Peak throughput SHALL be one byte per 3 cycles.
REQ-022 cnt SHALL increment by 1 per transfer and wrap 255->0.
REQ-023 Deasserting en SHALL not abort an issued read: REQ and CAP complete and the buffer keeps draining.
REQ-024 fifo_n>16 SHALL be treated as non-zero, with no other effect.

Reset
REQ-025 When rst=0: FSM->IDLE, buffer count and pointers->0, cnt->0, m_valid=0, m_data=0, fifo_eno=0, busy=0.
REQ-026 Reset during REQ or CAP SHALL discard the in-flight byte; no transfer completes in the reset cycle.

Configuration
REQ-027 Macro FIFO_READER_CKSUM_EN SHALL, when defined, add output port cksum (8 bits): 8-bit modular sum of all transferred bytes, updated each transfer, reset to 0.
REQ-028 Without FIFO_READER_CKSUM_EN, no cksum port or checksum logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-029 Reset: rst=0 for 2 cycles with fifo_n=5, en=1 -> fifo_eno=0, m_valid=0, cnt=0 throughout.
REQ-030 Drain: FIFO model preloaded with 0,1,2,3,4; en=1, m_ready=1 -> m_data sequence 0,1,2,3,4; fifo_eno pulses spaced exactly 3 cycles; cnt=5; no read at fifo_n=0.
REQ-031 Backpressure: m_ready=0, 4 bytes available -> exactly 2 reads, m_data=first byte held; then m_ready=1 -> remaining bytes in order, cnt=4.
REQ-032 Simultaneous events: buffer count=1, CAP coincides with a transfer -> count stays 1, next m_data = captured byte.
REQ-033 Mid-operation: en dropped in the REQ cycle -> CAP still captures, byte delivered, no further fifo_eno; rst=0 in CAP -> byte lost, all outputs at reset values.
REQ-034 Checksum (with FIFO_READER_CKSUM_EN): bytes 0x80,0x90,0x10 -> cksum=0x20; 256 transfers -> cnt wraps to 0.
